// File: rtl/eq_band_mixer.sv
// Equalizer recombiner: one shared MAC weights ten band samples by per-band Q2.10 gains and sums them.
// Capture-to-out_valid latency is NBANDS+2 cycles; strobes arriving while busy are dropped and flagged as overrun.
module eq_band_mixer #(
   parameter int NBANDS = 10,
   parameter int DW     = 24,
   parameter int GW     = 12,
   parameter int ACCW   = 40
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 sample_valid,
   input  logic [NBANDS*DW-1:0] band_in,
   input  logic                 gain_wr_en,
   input  logic [3:0]           gain_addr,
   input  logic [GW-1:0]        gain_data,
   output logic [DW-1:0]        audio_out,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int PW = DW + GW;
   localparam logic signed [GW-1:0] UNITY = GW'(1024);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             idx_q, idx_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic signed [DW-1:0]   band_q [NBANDS];
   logic signed [DW-1:0]   band_d [NBANDS];
   logic signed [GW-1:0]   gain_q [NBANDS];
   logic signed [GW-1:0]   gwork_q [NBANDS];
   logic signed [GW-1:0]   gwork_d [NBANDS];
   logic [DW-1:0]          audio_q, audio_d;
   logic                   out_valid_q, out_valid_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;

   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] rnd;
   logic [DW-1:0]          sat;
   logic                   capture;

   assign capture = (state_q == S_IDLE) && sample_valid && enable;
   assign prod    = PW'(band_q[idx_q]) * PW'(gwork_q[idx_q]);
   assign rnd     = (acc_q + ACCW'(512)) >>> 10;

   // Result fits when every bit above the DW-bit sign position agrees with it.
   always_comb begin
      sat = rnd[DW-1:0];
      if (!(&rnd[ACCW-1:DW-1]) && (|rnd[ACCW-1:DW-1])) begin
         sat = rnd[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NBANDS; k++) gain_q[k] <= UNITY;
      end else if (gain_wr_en && (int'(gain_addr) < NBANDS)) begin
         gain_q[gain_addr] <= gain_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      band_d      = band_q;
      gwork_d     = gwork_q;
      audio_d     = audio_q;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      overrun_d   = (overrun_q && !overrun_clr) || (sample_valid && enable && busy_q);

      case (state_q)
         S_IDLE: begin
            if (capture) begin
               for (int k = 0; k < NBANDS; k++) band_d[k] = band_in[k*DW +: DW];
               gwork_d = gain_q;
               acc_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + ACCW'(prod);
            if (idx_q == 4'(NBANDS - 1)) begin
               state_d = S_ROUND;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         S_ROUND: begin
            audio_d     = sat;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         audio_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int k = 0; k < NBANDS; k++) begin
            band_q[k]  <= '0;
            gwork_q[k] <= UNITY;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         audio_q     <= audio_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         band_q      <= band_d;
         gwork_q     <= gwork_d;
      end
   end

   assign audio_out = audio_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule
